// File: rtl/seq_pkg.sv
// Encodings and defaults shared by the pattern transmitter and the sequence detectors.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_PARITY = 2'b10,
    ST_DONE   = 2'b11
  } seq_state_e;

  localparam logic [3:0] SEQ_DEFAULT_PATTERN = 4'b1010;

endpackage

// File: rtl/seq_bit_ctr.sv
// Bit-index / repeat counter for seq_pattern_tx: idx wraps WIDTH-1 -> 0, decrementing rep.
module seq_bit_ctr #(
  parameter int WIDTH    = 4,
  parameter int REPEAT_W = 4,
  parameter int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                init,
  input  logic                adv,
  input  logic [REPEAT_W-1:0] count,
  output logic [IDX_W-1:0]    nxt_idx,
  output logic                last_bit,
  output logic                last_word
);

  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [REPEAT_W-1:0] rep_q, rep_d;

  assign last_bit  = (idx_q == IDX_W'(WIDTH - 1));
  assign last_word = (rep_q == REPEAT_W'(1));
  assign nxt_idx   = last_bit ? '0 : idx_q + IDX_W'(1);

  always_comb begin
    idx_d = idx_q;
    rep_d = rep_q;
    if (clr) begin
      idx_d = '0;
      rep_d = '0;
    end else if (init) begin
      idx_d = '0;
      rep_d = count;
    end else if (adv) begin
      idx_d = nxt_idx;
      if (last_bit) rep_d = rep_q - REPEAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      rep_q <= '0;
    end else begin
      idx_q <= idx_d;
      rep_q <= rep_d;
    end
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial MSB-first pattern transmitter with start/busy/done handshake and abort.
// Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit after every word.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] PATTERN  = WIDTH'(SEQ_DEFAULT_PATTERN),
  parameter int               REPEAT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                start,
  input  logic [REPEAT_W-1:0] count,
  input  logic                abort,
  output logic                o,
  output logic                valid,
  output logic                busy,
  output logic                done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             o_q, o_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             ctr_clr, ctr_init, ctr_adv;
  logic [IDX_W-1:0] nxt_idx;
  logic [IDX_W-1:0] nxt_sel;
  logic             last_bit, last_word;

  seq_bit_ctr #(
    .WIDTH    (WIDTH),
    .REPEAT_W (REPEAT_W),
    .IDX_W    (IDX_W)
  ) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .clr       (ctr_clr),
    .init      (ctr_init),
    .adv       (ctr_adv),
    .count     (count),
    .nxt_idx   (nxt_idx),
    .last_bit  (last_bit),
    .last_word (last_word)
  );

  // o is registered, so the bit loaded at each edge is the one for the next index
  assign nxt_sel = IDX_W'(WIDTH - 1) - nxt_idx;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    o_d      = 1'b0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    ctr_clr  = 1'b0;
    ctr_init = 1'b0;
    ctr_adv  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) word_d = data_in;
        if (start) begin
          ctr_init = 1'b1;
          if (count != '0) begin
            state_d = ST_SHIFT;
            o_d     = word_d[WIDTH-1];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
          ctr_clr = 1'b1;
        end else if (last_bit) begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
          state_d = ST_PARITY;
          o_d     = ^word_q;
          valid_d = 1'b1;
          busy_d  = 1'b1;
`else
          if (last_word) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            ctr_adv = 1'b1;
            o_d     = word_q[nxt_sel];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
`endif
        end else begin
          ctr_adv = 1'b1;
          o_d     = word_q[nxt_sel];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
`ifdef SEQ_PATTERN_TX_PARITY_EN
      ST_PARITY: begin
        if (abort) begin
          state_d = ST_IDLE;
          ctr_clr = 1'b1;
        end else if (last_word) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          // idx still sits on WIDTH-1, so advancing wraps it and consumes one repeat
          state_d = ST_SHIFT;
          ctr_adv = 1'b1;
          o_d     = word_q[WIDTH-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= PATTERN;
      o_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      o_q     <= o_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o     = o_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: stimulus queues expected bits, a monitor pops them.
module tb_seq_pattern_tx;

  localparam int W  = 4;
  localparam int RW = 4;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, load, start, abort;
  logic [W-1:0]  data_in;
  logic [RW-1:0] count;
  logic          o, valid, busy, done;

  always #5 clk = ~clk;

  seq_pattern_tx #(
    .WIDTH    (W),
    .PATTERN  (4'b1010),
    .REPEAT_W (RW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data_in (data_in),
    .start   (start),
    .count   (count),
    .abort   (abort),
    .o       (o),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  typedef struct packed {
    logic o;
    logic done;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         y_cnt = 0;
  logic [3:0] hist  = '0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic b, input logic d);
    exp_t e;
    e.o    = b;
    e.done = d;
    sb.push_back(e);
  endtask

  task automatic push_frame(input logic [W-1:0] word, input int cnt);
    for (int r = 0; r < cnt; r++) begin
      for (int i = 0; i < W; i++) push(word[W-1-i], 1'b0);
`ifdef SEQ_PATTERN_TX_PARITY_EN
      push(^word, 1'b0);
`endif
    end
    push(1'b0, 1'b1);
  endtask

  // Monitor: every presented bit or done pulse is checked against the queue head
  always @(negedge clk) begin
    if (!rst) begin
      if (valid || done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: o=%0b done=%0b with nothing queued", o, done);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_o", int'(o), int'(e.o));
          chk("sb_done", int'(done), int'(e.done));
        end
      end
      if (!valid) chk("o_zero_when_invalid", int'(o), 0);
      if (valid) begin
        if ({hist[2:0], o} == 4'b1010) y_cnt++;
        hist = {hist[2:0], o};
      end else begin
        hist = '0;
      end
    end
  end

  task automatic run_frame(input string nm, input logic ld, input logic [W-1:0] d,
                           input int cnt, input logic [W-1:0] word, input bit poke);
    int busy_n, done_at, first_v;
    @(posedge clk);
    #1;
    load    = ld;
    data_in = d;
    start   = 1'b1;
    count   = RW'(cnt);
    push_frame(word, cnt);
    busy_n  = 0;
    done_at = 0;
    first_v = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 2) begin
        start = 1'b0;
        load  = 1'b0;
      end
      if (poke && i == 4) begin
        start   = 1'b1;
        load    = 1'b1;
        data_in = '0;
        count   = RW'(1);
      end
      if (poke && i == 6) begin
        start = 1'b0;
        load  = 1'b0;
      end
      if (valid && first_v == 0) first_v = i;
      if (busy) busy_n++;
      if (done) begin
        done_at = i;
        break;
      end
    end
    if (done_at == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: no done within 300 cycles", nm);
    end
    chk({nm, "_done_cycle"}, done_at, 2 + cnt * (W + P));
    chk({nm, "_busy_cycles"}, busy_n, cnt * (W + P));
    chk({nm, "_first_valid"}, first_v, (cnt > 0) ? 2 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int y0;
    rst = 1'b1; load = 1'b0; start = 1'b0; abort = 1'b0;
    data_in = '0; count = '0;
    repeat (2) @(negedge clk);
    chk("rst_o", int'(o), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // 1: default word, single repeat
    y0 = y_cnt;
    run_frame("t1", 1'b0, '0, 1, 4'b1010, 1'b0);
`ifndef SEQ_PATTERN_TX_PARITY_EN
    chk("t1_detector_hits", y_cnt - y0, 1);
`endif

    // 2: two contiguous repeats
    y0 = y_cnt;
    run_frame("t2", 1'b0, '0, 2, 4'b1010, 1'b0);
`ifndef SEQ_PATTERN_TX_PARITY_EN
    chk("t2_detector_hits", y_cnt - y0, 3);
`endif

    // 3: load with start, start/load pokes while busy must be ignored
    run_frame("t3", 1'b1, 4'b1100, 3, 4'b1100, 1'b1);

    // 4: abort after two bits, then a fresh full word from the MSB
    @(posedge clk);
    #1 start = 1'b1; count = RW'(1);
    push(1'b1, 1'b0);
    push(1'b1, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("t4_abort_o", int'(o), 0);
    chk("t4_abort_valid", int'(valid), 0);
    chk("t4_abort_busy", int'(busy), 0);
    chk("t4_abort_done", int'(done), 0);
    repeat (3) @(negedge clk);
    chk("t4_no_done_later", int'(done), 0);
    run_frame("t4_fresh", 1'b0, '0, 1, 4'b1100, 1'b0);

    // 5: zero count, then async reset mid-frame restores PATTERN
    run_frame("t5_zero", 1'b0, '0, 0, 4'b1100, 1'b0);
    @(posedge clk);
    #1 start = 1'b1; count = RW'(3);
    push_frame(4'b1100, 3);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_o", int'(o), 0);
    chk("t5_rst_valid", int'(valid), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_done", int'(done), 0);
    sb.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    run_frame("t5_pattern", 1'b0, '0, 1, 4'b1010, 1'b0);

`ifdef SEQ_PATTERN_TX_PARITY_EN
    // 6: parity cycles after every word
    run_frame("t6_par0", 1'b0, '0, 2, 4'b1010, 1'b0);
    run_frame("t6_par1", 1'b1, 4'b1011, 1, 4'b1011, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
